// File: rtl/gam_node_mem_arbiter.sv
// GAM node memory arbiter: round-robin grant with
// beat locking, lock watchdog and read-return steering.
package GAM_package;
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } RD_WR_T;
endpackage

module gam_node_mem_arbiter
  import GAM_package::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [2:0]          lock,
  input  logic [2:0]          rd_wr_i,
  input  logic [3*ADDR_W-1:0] addr_i,
  input  logic [3*DATA_W-1:0] wdata_i,
  output logic [2:0]          gnt,
  output logic                mem_en,
  output logic                mem_rd_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   rdata,
  output logic [2:0]          rvalid,
  output logic                busy,
  output logic                lock_timeout
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t        state_q;
  logic [2:0]    gnt_q;
  logic [2:0]    gnt_d;
  logic [1:0]    last_q;
  logic [1:0]    last_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    rvalid_q;
  logic [2:0]    rvalid_d;
  logic          lock_timeout_q;
  logic          lock_timeout_d;

  logic [1:0]        own;
  logic              beat;
  logic              acc;
  logic              held;
  logic              expire;
  logic              keep;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        pick;
  logic [1:0]        pick_idx;

  // Decode the one-hot grant into the owner index.
  always_comb begin
    own = 2'd0;
    unique case (1'b1)
      gnt_q[2]: own = 2'd2;
      gnt_q[1]: own = 2'd1;
      default:  own = 2'd0;
    endcase
  end

  // Steer the owner's command onto the RAM port.
  always_comb begin
    beat      = |(gnt_q & req);
    acc       = beat & ~reset;
    sel_rw    = rd_wr_i[own];
    sel_addr  = addr_i[int'(own)*ADDR_W +: ADDR_W];
    sel_wdata = wdata_i[int'(own)*DATA_W +: DATA_W];
    mem_en    = acc;
    mem_rd_wr = acc ? sel_rw : READ;
    mem_addr  = acc ? sel_addr : '0;
    mem_wdata = acc ? sel_wdata : '0;
  end

  // Rotating search starting after the last owner.
  always_comb begin
    pick     = 3'b000;
    pick_idx = last_q;
    for (int i = 1; i <= 3; i++) begin
      if (pick == 3'b000 &&
          req[(int'(last_q) + i) % 3]) begin
        pick     = 3'b001 << ((int'(last_q) + i) % 3);
        pick_idx = 2'((int'(last_q) + i) % 3);
      end
    end
  end

  // Lock watchdog and next-grant selection.
  always_comb begin
    cnt_inc        = cnt_q + CW'(1);
    held           = beat & lock[own];
    expire         = held & (cnt_inc >= CW'(LOCK_MAX));
    keep           = held & ~expire;
    gnt_d          = keep ? gnt_q : pick;
    cnt_d          = keep ? cnt_inc : '0;
    last_d         = last_q;
    if (!keep && pick != 3'b000) begin
      last_d = pick_idx;
    end
    lock_timeout_d = lock_timeout_q | expire;
    rvalid_d       = '0;
    if (acc && sel_rw == READ) begin
      rvalid_d = gnt_q;
    end
  end

  // Arbiter state, grant and return strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      last_q         <= 2'd2;
      cnt_q          <= '0;
      rvalid_q       <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= (gnt_d != 3'b000) ? OWNED : IDLE;
      gnt_q          <= gnt_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      rvalid_q       <= rvalid_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign gnt          = gnt_q;
  assign busy         = (state_q == OWNED);
  assign rvalid       = rvalid_q & {3{~reset}};
  assign rdata        = (rvalid != 3'b000) ? mem_rdata : '0;
  assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_gam_node_mem_arbiter.sv
// Bench for gam_node_mem_arbiter: directed scenarios plus
// random traffic against a cycle-level reference model.
module tb_gam_node_mem_arbiter;
  import GAM_package::*;

  localparam int LMAX = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [2:0]  rd_wr_i;
  logic [23:0] addr_i;
  logic [95:0] wdata_i;
  logic [2:0]  gnt;
  logic        mem_en;
  logic        mem_rd_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic [2:0]  rvalid;
  logic        busy;
  logic        lock_timeout;

  gam_node_mem_arbiter #(
    .ADDR_W(8), .DATA_W(32), .LOCK_MAX(LMAX)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .rd_wr_i(rd_wr_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt(gnt), .mem_en(mem_en), .mem_rd_wr(mem_rd_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata), .rvalid(rvalid),
    .busy(busy), .lock_timeout(lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int beats   = 0;

  logic [31:0] ram [256];
  logic [31:0] mmem [256];
  logic [31:0] ram_rd;

  // Single-port synchronous RAM seen by the DUT.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rd_wr == WRITE) ram[mem_addr] <= mem_wdata;
      else ram_rd <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_rd;

  always @(negedge clk) if (mem_en) beats <= beats + 1;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h0001_0001) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner as int (-1 idle), plain counters.
  bit          armed = 0;
  int          m_own, m_last, m_cnt, m_pend;
  bit          m_to;
  logic [31:0] m_prd;

  task automatic m_step();
    bit beat, held;
    int a, nxt;
    if (reset) begin
      m_own = -1; m_last = 2; m_cnt = 0; m_to = 0; m_pend = -1;
      armed = 1;
      return;
    end
    if (!armed) return;
    beat = 0;
    if (m_own >= 0) beat = req[m_own];
    m_pend = -1;
    held = 0;
    if (beat) begin
      a = int'(addr_i[m_own*8 +: 8]);
      if (rd_wr_i[m_own] == WRITE) mmem[a] = wdata_i[m_own*32 +: 32];
      else begin
        m_pend = m_own;
        m_prd  = mmem[a];
      end
      held = lock[m_own];
    end
    if (held && m_cnt + 1 >= LMAX) m_to = 1;
    if (held && m_cnt + 1 < LMAX) m_cnt++;
    else begin
      m_cnt = 0;
      nxt = -1;
      for (int i = 1; i <= 3; i++)
        if (nxt < 0 && req[(m_last + i) % 3]) nxt = (m_last + i) % 3;
      m_own = nxt;
      if (nxt >= 0) m_last = nxt;
    end
  endtask

  task automatic m_check();
    logic [2:0]  eg, erv;
    logic        een, erw;
    logic [7:0]  ea;
    logic [31:0] ed, er;
    eg = 3'b000; een = 0; erw = READ; ea = 0; ed = 0;
    if (m_own >= 0) begin
      eg = 3'b001 << m_own;
      if (req[m_own] && !reset) begin
        een = 1;
        erw = rd_wr_i[m_own];
        ea  = addr_i[m_own*8 +: 8];
        ed  = wdata_i[m_own*32 +: 32];
      end
    end
    erv = 3'b000; er = 0;
    if (m_pend >= 0 && !reset) begin
      erv = 3'b001 << m_pend;
      er  = m_prd;
    end
    chk("m_gnt", gnt, eg);
    chk("m_busy", busy, eg != 0);
    chk("m_en", mem_en, een);
    chk("m_rw", mem_rd_wr, erw);
    chk("m_addr", mem_addr, ea);
    chk("m_wdata", mem_wdata, ed);
    chk("m_rvalid", rvalid, erv);
    chk("m_rdata", rdata, er);
    chk("m_to", lock_timeout, m_to);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (armed) m_check();
      @(posedge clk);
      m_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int k, input logic [7:0] a,
                       input logic [31:0] d);
    addr_i[k*8 +: 8]   = a;
    wdata_i[k*32 +: 32] = d;
  endtask

  int b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]  = init_word(i);
      mmem[i] = init_word(i);
    end
    ram_rd = 0;
    reset = 1; req = 0; lock = 0; rd_wr_i = 0; addr_i = 0; wdata_i = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_to", lock_timeout, 0);

    // Unlocked three-way rotation.
    cyc(); req = 3'b111;
    set_a(0, 8'h10, 0); set_a(1, 8'h20, 0); set_a(2, 8'h30, 0);
    #2 chk("rr_idle", gnt, 3'b000);
    cyc(); #2 chk("rr_g0", gnt, 3'b001);
    chk("rr_a0", mem_addr, 8'h10);
    cyc(); #2 chk("rr_g1", gnt, 3'b010);
    chk("rr_a1", mem_addr, 8'h20);
    chk("rr_rv0", rvalid, 3'b001);
    chk("rr_rd0", rdata, init_word(8'h10));
    cyc(); #2 chk("rr_g2", gnt, 3'b100);
    chk("rr_a2", mem_addr, 8'h30);
    chk("rr_rd1", rdata, init_word(8'h20));
    cyc(); #2 chk("rr_g3", gnt, 3'b001);
    chk("rr_rv2", rvalid, 3'b100);
    cyc(); req = 0;
    repeat (2) cyc();

    // Locked read-modify-write by requester 0.
    req = 3'b011; lock = 3'b001; rd_wr_i = 3'b000;
    set_a(0, 8'h05, 0); set_a(1, 8'h05, 0);
    #2 chk("lk_idle", gnt, 3'b000);
    cyc(); #2 chk("lk_g1", gnt, 3'b001);
    chk("lk_rd_addr", mem_addr, 8'h05);
    cyc(); rd_wr_i = 3'b001; set_a(0, 8'h05, 32'hDEAD_BEEF);
    #2 chk("lk_g2", gnt, 3'b001);
    chk("lk_wr", mem_rd_wr, WRITE);
    chk("lk_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc(); set_a(0, 8'h06, 32'h1234_5678); lock = 0;
    #2 chk("lk_g3", gnt, 3'b001);
    cyc(); req = 3'b010;
    #2 chk("lk_hand", gnt, 3'b010);
    cyc(); req = 0;
    #2 chk("lk_rv", rvalid, 3'b010);
    chk("lk_rb", rdata, 32'hDEAD_BEEF);
    repeat (2) cyc();

    // Watchdog forces requester 2 off after LMAX beats.
    req = 3'b110; lock = 3'b100; rd_wr_i = 0;
    set_a(2, 8'h40, 0); set_a(1, 8'h41, 0);
    #2 chk("wd_idle", gnt, 3'b000);
    for (int i = 0; i < LMAX; i++) begin
      cyc(); #2 chk("wd_hold", gnt, 3'b100);
      chk("wd_to0", lock_timeout, 0);
    end
    cyc(); #2 chk("wd_move", gnt, 3'b010);
    chk("wd_to1", lock_timeout, 1);
    cyc(); #2 chk("wd_back", gnt, 3'b100);
    cyc(); req = 0; lock = 0;
    repeat (3) cyc();
    #2 chk("wd_sticky", lock_timeout, 1);

    // Sole unlocked requester streams beats.
    cyc(); req = 3'b010; b0 = beats;
    #2 chk("so_idle", gnt, 3'b000);
    for (int i = 0; i < 10; i++) begin
      cyc(); #2 chk("so_gnt", gnt, 3'b010);
      chk("so_busy", busy, 1);
    end
    cyc(); req = 0;
    #2 chk("so_drop", gnt, 3'b010);
    cyc(); #2 chk("so_gnt0", gnt, 3'b000);
    chk("so_busy0", busy, 0);
    chk("so_beats", 32'(beats - b0), 10);

    // Reset in the middle of a lock.
    cyc(); req = 3'b001; lock = 3'b001; rd_wr_i = 0;
    set_a(0, 8'h07, 0);
    #2 chk("mr_idle", gnt, 3'b000);
    cyc(); #2 chk("mr_g", gnt, 3'b001);
    cyc(); reset = 1;
    #2 chk("mr_en", mem_en, 0);
    chk("mr_rv", rvalid, 0);
    cyc(); reset = 0; req = 0; lock = 0;
    #2 chk("mr_gnt", gnt, 0);
    chk("mr_rv2", rvalid, 0);
    chk("mr_to", lock_timeout, 0);
    cyc(); req = 3'b111;
    #2 chk("mr_idle2", gnt, 3'b000);
    cyc(); #2 chk("mr_first", gnt, 3'b001);
    cyc(); req = 0;
    repeat (2) cyc();

    // Short pulse on requester 0; last owner retained.
    req = 3'b001; b0 = beats;
    #2 chk("pu_idle", gnt, 3'b000);
    cyc(); #2 chk("pu_g", gnt, 3'b001);
    cyc(); req = 0;
    cyc(); cyc();
    #2 chk("pu_gnt0", gnt, 3'b000);
    chk("pu_beats", 32'(beats - b0), 1);
    cyc(); req = 3'b111;
    cyc(); #2 chk("pu_next", gnt, 3'b010);
    cyc(); req = 0;
    repeat (2) cyc();

    // Random traffic against the model.
    repeat (3000) begin
      cyc();
      reset   = ($urandom_range(0, 199) == 0);
      req     = 3'($urandom);
      lock    = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom | $urandom);
      rd_wr_i = 3'($urandom);
      for (int k = 0; k < 3; k++)
        set_a(k, 8'($urandom_range(0, 15)), $urandom);
    end
    cyc(); reset = 0; req = 0; lock = 0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
